// File: rtl/deflate_matrix.sv
// deflate_matrix
//   Rank-1 deflation A' = A - lambda * v * v^T, one element per clock.
//   A start in IDLE captures A, v and lambda during LOAD. RUN then writes
//   out_matrix row-major, one element per cycle. DONE pulses done for one
//   cycle and returns to IDLE.
//
//   Fixed point: matrix, vector and lambda share FRAC_BITS fractional bits.
//   lambda*v[i]*v[j] carries 3*FRAC_BITS fractional bits. Shifting it right
//   arithmetically by 2*FRAC_BITS aligns it with A.
//
//   Optional feature (macro DEFLATE_SAT_EN):
//     defined   -> the result is clamped to the signed 32-bit range
//     undefined -> the result keeps its low 32 bits (two's-complement wrap)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   start         run request, honoured only in IDLE
//   timed_matrix  A,      [SIZE_N][SIZE_N] x signed 32-bit
//   eig_vector    v,      [SIZE_N][1]      x signed 32-bit
//   eig_value     lambda, signed 32-bit
//   busy          high in LOAD and RUN
//   done          one-cycle pulse once out_matrix is complete
//   out_matrix    A',     [SIZE_N][SIZE_N] x signed 32-bit

// Combinational per-element arithmetic.
module deflate_elem #(
  parameter int FRAC_BITS = 0
) (
  input  logic signed [31:0] a,
  input  logic signed [31:0] vi,
  input  logic signed [31:0] vj,
  input  logic signed [31:0] lam,
  output logic        [31:0] r
);
  localparam logic signed [97:0] MAXV = 98'sd2147483647;
  localparam logic signed [97:0] MINV = -98'sd2147483648;

  logic signed [95:0] p;
  logic signed [95:0] s;
  logic signed [97:0] rf;

  always_comb begin
    p  = 96'(lam) * 96'(vi) * 96'(vj);
    s  = p >>> (2 * FRAC_BITS);
    rf = 98'(a) - 98'(s);
`ifdef DEFLATE_SAT_EN
    if (rf > MAXV)      r = 32'h7fff_ffff;
    else if (rf < MINV) r = 32'h8000_0000;
    else                r = rf[31:0];
`else
    r = rf[31:0];
`endif
  end
endmodule

module deflate_matrix #(
  parameter int SIZE_N    = 8,
  parameter int FRAC_BITS = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [SIZE_N-1:0][SIZE_N-1:0][31:0] timed_matrix,
  input  logic [SIZE_N-1:0][0:0][31:0]        eig_vector,
  input  logic [31:0]                         eig_value,
  output logic                               busy,
  output logic                               done,
  output logic [SIZE_N-1:0][SIZE_N-1:0][31:0] out_matrix
);
  localparam int IW = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
  localparam logic [IW-1:0] LAST = IW'(SIZE_N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // Snapshot of the operands; inputs are free to change after LOAD.
  typedef struct packed {
    logic [SIZE_N-1:0][SIZE_N-1:0][31:0] a;
    logic [SIZE_N-1:0][0:0][31:0]        v;
    logic [31:0]                         lam;
  } cap_t;

  state_t        state, nxt;
  cap_t          cap;
  logic [IW-1:0] i, j;
  logic          last;
  logic [31:0]   res;

  assign last = (i == LAST) && (j == LAST);

  deflate_elem #(.FRAC_BITS(FRAC_BITS)) u_elem (
    .a  (cap.a[i][j]),
    .vi (cap.v[i][0]),
    .vj (cap.v[j][0]),
    .lam(cap.lam),
    .r  (res)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (start) nxt = LOAD;
      LOAD: begin busy = 1'b1; nxt = RUN; end
      RUN:  begin busy = 1'b1; if (last) nxt = DONE; end
      DONE: begin done = 1'b1; nxt = IDLE; end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cap        <= '0;
      out_matrix <= '0;
      i          <= '0;
      j          <= '0;
    end else begin
      case (state)
        LOAD: begin
          cap.a   <= timed_matrix;
          cap.v   <= eig_vector;
          cap.lam <= eig_value;
          i       <= '0;
          j       <= '0;
        end
        RUN: begin
          out_matrix[i][j] <= res;
          if (j == LAST) begin
            j <= '0;
            i <= last ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
